cnt_stream_chk: RTL and testbench

//  Receive-side checker for the pipelined 8-bit count stream (x) and pattern-flag (y)

---
 rtl/cnt_stream_chk.sv | 116 +++++++++++
 tb/tb_cnt_stream_chk.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_stream_chk.sv
// Receive-side checker for the 8-bit count stream: locks onto the incoming count,
// flags out-of-range steps while locked, and latches the pattern-error flag.
module cnt_stream_chk #(
  parameter int ERR_W    = 8,
  parameter int LOCK_N   = 4,
  parameter int MAX_STEP = 1
) (
  input  logic             clka,
  input  logic             rstn,
  input  logic             vld,
  input  logic [7:0]       x,
  input  logic             y,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             sticky_y,
  output logic [7:0]       last
);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam logic [7:0]       MAX_STEP_B = 8'(MAX_STEP);
  localparam logic [3:0]       LOCK_N_B   = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_p1, state_p0;
  logic [3:0]       gcnt_p1, gcnt_p0;
  logic [7:0]       last_p1, last_p0;
  logic [ERR_W-1:0] err_p1, err_p0;
  logic             pulse_p1, pulse_p0;
  logic             sticky_p1, sticky_p0;
  logic [7:0]       delta_p0;
  logic             good_p0;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_ONE;
  endfunction

  // Stage p0: step classification and next-state decision
  assign delta_p0 = x - last_p1;
  assign good_p0  = (delta_p0 <= MAX_STEP_B);

  always_comb begin
    state_p0  = state_p1;
    gcnt_p0   = gcnt_p1;
    last_p0   = last_p1;
    err_p0    = err_p1;
    pulse_p0  = 1'b0;
    sticky_p0 = sticky_p1;
    if (clr) begin
      state_p0  = UNLOCK;
      gcnt_p0   = 4'd0;
      last_p0   = 8'h00;
      err_p0    = '0;
      sticky_p0 = 1'b0;
    end else if (vld) begin
      last_p0 = x;
      if (y) sticky_p0 = 1'b1;
      unique case (state_p1)
        UNLOCK: begin
          gcnt_p0  = 4'd0;
          state_p0 = ACQ;
        end
        ACQ: begin
          if (good_p0) begin
            gcnt_p0 = gcnt_p1 + 4'd1;
            if (gcnt_p1 + 4'd1 == LOCK_N_B) state_p0 = LOCK;
          end else begin
            gcnt_p0 = 4'd0;
          end
        end
        LOCK: begin
          if (!good_p0) begin
            pulse_p0 = 1'b1;
            err_p0   = sat_inc(err_p1);
            gcnt_p0  = 4'd0;
            state_p0 = ACQ;
          end
        end
        default: state_p0 = UNLOCK;
      endcase
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state_p1  <= UNLOCK;
      gcnt_p1   <= 4'd0;
      last_p1   <= 8'h00;
      err_p1    <= '0;
      pulse_p1  <= 1'b0;
      sticky_p1 <= 1'b0;
    end else begin
      state_p1  <= state_p0;
      gcnt_p1   <= gcnt_p0;
      last_p1   <= last_p0;
      err_p1    <= err_p0;
      pulse_p1  <= pulse_p0;
      sticky_p1 <= sticky_p0;
    end
  end

  assign locked    = (state_p1 == LOCK);
  assign err_pulse = pulse_p1;
  assign err_cnt   = err_p1;
  assign sticky_y  = sticky_p1;
  assign last      = last_p1;

endmodule

// File: tb/tb_cnt_stream_chk.sv
// Directed bench for cnt_stream_chk: a behavioural model queues expected outputs
// per driven sample; they are popped and compared one cycle later.
module tb_cnt_stream_chk;
  localparam int ERR_W    = 2;
  localparam int LOCK_N   = 4;
  localparam int MAX_STEP = 1;

  logic             clka = 1'b0;
  logic             rstn;
  logic             vld;
  logic [7:0]       x;
  logic             y;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic             sticky_y;
  logic [7:0]       last;

  cnt_stream_chk #(.ERR_W(ERR_W), .LOCK_N(LOCK_N), .MAX_STEP(MAX_STEP)) dut (
    .clka(clka), .rstn(rstn), .vld(vld), .x(x), .y(y), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .sticky_y(sticky_y), .last(last)
  );

  always #5 clka = ~clka;

  typedef struct packed {
    logic             locked;
    logic             pulse;
    logic [ERR_W-1:0] err;
    logic             sticky;
    logic [7:0]       last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;

  // model state: 0 unlock, 1 acquire, 2 locked
  int         m_st;
  int         m_cnt;
  logic [7:0] m_last;
  int         m_err;
  logic       m_sticky;
  logic       m_pulse;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_last = 8'h00; m_err = 0; m_sticky = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] xv, input logic yv, input logic c);
    logic [7:0] d;
    m_pulse = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      d = xv - m_last;
      if (yv) m_sticky = 1'b1;
      if (m_st == 0) begin
        m_cnt = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (int'(d) <= MAX_STEP) begin
          m_cnt++;
          if (m_cnt == LOCK_N) m_st = 2;
        end else m_cnt = 0;
      end else if (int'(d) > MAX_STEP) begin
        m_pulse = 1'b1;
        if (m_err < (1 << ERR_W) - 1) m_err++;
        m_cnt = 0; m_st = 1;
      end
      m_last = xv;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] xv, input logic yv, input logic c);
    exp_t e;
    vld = v; x = xv; y = yv; clr = c;
    model_step(v, xv, yv, c);
    e.locked = (m_st == 2);
    e.pulse  = m_pulse;
    e.err    = ERR_W'(m_err);
    e.sticky = m_sticky;
    e.last   = m_last;
    q.push_back(e);
    @(posedge clka);
    #1;
    vld = 1'b0; y = 1'b0; clr = 1'b0;
    if (err_pulse === 1'b1) pulses++;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("sb_locked", 32'(locked), 32'(e.locked));
      chk("sb_pulse",  32'(err_pulse), 32'(e.pulse));
      chk("sb_errcnt", 32'(err_cnt), 32'(e.err));
      chk("sb_sticky", 32'(sticky_y), 32'(e.sticky));
      chk("sb_last",   32'(last), 32'(e.last));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         p0;
    model_reset();
    // reset with active-looking inputs
    rstn = 1'b0; vld = 1'b1; x = 8'h55; y = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse",  32'(err_pulse), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_sticky", 32'(sticky_y), 32'd0);
    chk("rst_last",   32'(last), 32'h00);
    vld = 1'b0; y = 1'b0;
    rstn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_last", 32'(last), 32'h00);

    // lock on 0..4
    for (int i = 0; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("lock_after4", 32'(locked), 32'd1);
    chk("lock_err0",   32'(err_cnt), 32'd0);

    // wrap and stall while locked
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hfa + i), 1'b0, 1'b0);
    p0 = pulses;
    step(1'b1, 8'hff, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    chk("wrap_locked", 32'(locked), 32'd1);
    chk("wrap_last",   32'(last), 32'h01);
    chk("wrap_nopulse", 32'(pulses - p0), 32'd0);

    // error in lock, relock, jump in ACQ gives no pulse
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 12; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b0);
    chk("err_pulse",  32'(err_pulse), 32'd1);
    chk("err_cnt1",   32'(err_cnt), 32'd1);
    chk("err_unlock", 32'(locked), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("err_oneshot", 32'(err_pulse), 32'd0);
    for (int i = 8'h14; i <= 8'h16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("relock_not_yet", 32'(locked), 32'd0);
    step(1'b1, 8'h17, 1'b0, 1'b0);
    chk("relock", 32'(locked), 32'd1);
    step(1'b1, 8'h50, 1'b0, 1'b0);
    step(1'b1, 8'h60, 1'b0, 1'b0);
    chk("acq_jump_nopulse", 32'(err_pulse), 32'd0);
    chk("acq_jump_errcnt",  32'(err_cnt), 32'd2);
    for (int i = 8'h61; i <= 8'h64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("relock2", 32'(locked), 32'd1);

    // saturation: five lock/error cycles
    step(1'b0, 8'h00, 1'b0, 1'b1);
    p0 = pulses;
    b = 8'h80;
    step(1'b1, b, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(b + 8'(i)), 1'b0, 1'b0);
      b = b + 8'h40;
      step(1'b1, b, 1'b0, 1'b0);
    end
    chk("sat_errcnt", 32'(err_cnt), 32'd3);
    chk("sat_pulses", 32'(pulses - p0), 32'd5);

    // async reset mid-operation
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(b + 8'(i)), 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_errcnt", 32'(err_cnt), 32'd0);
    chk("async_last",   32'(last), 32'h00);
    model_reset();
    @(negedge clka);
    rstn = 1'b1;
    @(posedge clka);
    #1;

    // sticky y and clr priority
    step(1'b1, 8'h20, 1'b1, 1'b0);
    chk("sticky_set", 32'(sticky_y), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    chk("sticky_hold", 32'(sticky_y), 32'd1);
    step(1'b1, 8'h40, 1'b1, 1'b1);
    chk("clr_sticky", 32'(sticky_y), 32'd0);
    chk("clr_last",   32'(last), 32'h00);
    chk("clr_locked", 32'(locked), 32'd0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    chk("after_clr_last", 32'(last), 32'h40);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
